viterbi_traceback: RTL and testbench

//  Frame-based survivor-path manager between the ACS unit and the 24x4096 survivor SRAM.

---
 rtl/viterbi_traceback.sv | 232 +++++++++++++++++++++++
 tb/tb_viterbi_traceback.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Survivor-path manager: stores ACS decision vectors per trellis step, traces back from the
// end state, packs decoded bits 24 per SRAM word, then streams them out in forward order.
module viterbi_traceback #(
    parameter int NS       = 16,
    parameter int MAX_LEN  = 2048,
    parameter int OUT_BASE = 2048
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dec_valid_i,
    input  logic [NS-1:0]          dec_i,
    input  logic                   dec_first_i,
    input  logic                   dec_last_i,
    input  logic [$clog2(NS)-1:0]  end_state_i,
    output logic                   in_ready_o,
    output logic                   mem_wr_en_o,
    output logic                   mem_rd_en_o,
    output logic [11:0]            mem_addr_o,
    output logic [23:0]            mem_wdata_o,
    input  logic [23:0]            mem_rdata_i,
    output logic                   bit_valid_o,
    output logic                   bit_o,
    output logic                   bit_last_o,
    input  logic                   bit_ready_i,
    output logic                   busy_o,
    output logic                   err_len_o
);

    localparam int M   = $clog2(NS);
    localparam int AW  = 12;
    localparam int DW  = 24;
    localparam int TW  = $clog2(MAX_LEN + 1);
    localparam int WW  = $clog2(MAX_LEN / DW + 2);
    localparam int PW  = 5;
    localparam logic [PW-1:0] LAST_POS = PW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_TB, S_TB_END, S_RO_READ, S_RO_LOAD, S_RO_EMIT
    } state_t;

    state_t        state_q;

    // Forward (write) position: step, bit-in-word and word index kept in step.
    logic [TW-1:0] t_q;
    logic [PW-1:0] wpos_q;
    logic [WW-1:0] wword_q;
    logic [TW-1:0] len_q;

    // Traceback: read pointer runs one cycle ahead of the step being processed.
    logic [M-1:0]  st_q;
    logic [TW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_pos_q;
    logic [WW-1:0] rd_word_q;
    logic          rd_left_q;
    logic          pend_q;
    logic [PW-1:0] pr_pos_q;
    logic [WW-1:0] pr_word_q;
    logic [DW-1:0] pack_q;

    // Readout.
    logic [WW-1:0] ro_word_q;
    logic [PW-1:0] ro_pos_q;
    logic [TW-1:0] out_t_q;
    logic [DW-1:0] shreg_q;
    logic          bit_valid_q;
    logic          err_q;

    logic          accept, beat_first, beat_ovf, beat_wr;
    logic [TW-1:0] beat_t;
    logic [PW-1:0] beat_pos;
    logic [WW-1:0] beat_word;
    logic          arrive, word_wr, issue_rd, u;
    logic [NS-1:0] dec_vec;

    assign in_ready_o = (state_q == S_IDLE) || (state_q == S_WRITE);
    assign accept     = dec_valid_i && in_ready_o && rst_i;
    assign beat_first = accept && dec_first_i;
    assign beat_ovf   = accept && !dec_first_i && (state_q == S_WRITE) && (t_q == TW'(MAX_LEN));
    assign beat_wr    = beat_first || (accept && (state_q == S_WRITE) && !beat_ovf);
    assign beat_t     = beat_first ? '0 : t_q;
    assign beat_pos   = beat_first ? '0 : wpos_q;
    assign beat_word  = beat_first ? '0 : wword_q;

    assign arrive   = (state_q == S_TB) && pend_q;
    assign u        = st_q[0];
    assign word_wr  = arrive && (pr_pos_q == '0);
    assign issue_rd = (state_q == S_TB) && rd_left_q && !word_wr;
    assign dec_vec  = mem_rdata_i[NS-1:0];

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        mem_wr_en_o = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (beat_wr) begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = AW'(beat_t);
            mem_wdata_o = DW'(dec_i);
        end else if (word_wr) begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = AW'(OUT_BASE) + AW'(pr_word_q);
            mem_wdata_o = pack_q | (DW'(u) << pr_pos_q);
        end else if (issue_rd) begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = AW'(rd_ptr_q);
        end else if (state_q == S_RO_READ) begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = AW'(OUT_BASE) + AW'(ro_word_q);
        end
    end

    assign bit_valid_o = bit_valid_q;
    assign bit_o       = bit_valid_q && shreg_q[0];
    assign bit_last_o  = bit_valid_q && (out_t_q == len_q - TW'(1));
    assign busy_o      = (state_q != S_IDLE);
    assign err_len_o   = err_q;

    // NOTE: sequential state uses non-blocking assignments only; the external SRAM is never reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            wpos_q      <= '0;
            wword_q     <= '0;
            len_q       <= '0;
            st_q        <= '0;
            rd_ptr_q    <= '0;
            rd_pos_q    <= '0;
            rd_word_q   <= '0;
            rd_left_q   <= 1'b0;
            pend_q      <= 1'b0;
            pr_pos_q    <= '0;
            pr_word_q   <= '0;
            pack_q      <= '0;
            ro_word_q   <= '0;
            ro_pos_q    <= '0;
            out_t_q     <= '0;
            shreg_q     <= '0;
            bit_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WRITE: begin
                    if (beat_wr) begin
                        t_q     <= beat_t + TW'(1);
                        wpos_q  <= (beat_pos == LAST_POS) ? '0 : beat_pos + PW'(1);
                        wword_q <= beat_word + WW'(beat_pos == LAST_POS);
                        if (dec_last_i) begin
                            len_q     <= beat_t + TW'(1);
                            st_q      <= end_state_i;
                            rd_ptr_q  <= beat_t;
                            rd_pos_q  <= beat_pos;
                            rd_word_q <= beat_word;
                            rd_left_q <= 1'b1;
                            pend_q    <= 1'b0;
                            pack_q    <= '0;
                            state_q   <= S_TB;
                        end else begin
                            state_q   <= S_WRITE;
                        end
                    end else if (beat_ovf) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_TB: begin
                    pend_q <= issue_rd;
                    if (issue_rd) begin
                        rd_ptr_q  <= rd_ptr_q - TW'(1);
                        pr_pos_q  <= rd_pos_q;
                        pr_word_q <= rd_word_q;
                        rd_pos_q  <= (rd_pos_q == '0) ? LAST_POS : rd_pos_q - PW'(1);
                        if (rd_pos_q == '0)
                            rd_word_q <= rd_word_q - WW'(1);
                        if (rd_ptr_q == '0)
                            rd_left_q <= 1'b0;
                    end
                    if (arrive) begin
                        // Step back to the predecessor selected by this step's survivor decision.
                        st_q <= {dec_vec[st_q], st_q[M-1:1]};
                        if (word_wr)
                            pack_q <= '0;
                        else
                            pack_q[pr_pos_q] <= u;
                        if (word_wr && pr_word_q == '0)
                            state_q <= S_TB_END;
                    end
                end

                S_TB_END: begin
                    ro_word_q <= '0;
                    out_t_q   <= '0;
                    state_q   <= S_RO_READ;
                end

                S_RO_READ: state_q <= S_RO_LOAD;

                S_RO_LOAD: begin
                    shreg_q     <= mem_rdata_i;
                    ro_pos_q    <= '0;
                    bit_valid_q <= 1'b1;
                    state_q     <= S_RO_EMIT;
                end

                S_RO_EMIT: begin
                    if (bit_ready_i) begin
                        if (out_t_q == len_q - TW'(1)) begin
                            bit_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            out_t_q <= out_t_q + TW'(1);
                            if (ro_pos_q == LAST_POS) begin
                                bit_valid_q <= 1'b0;
                                ro_word_q   <= ro_word_q + WW'(1);
                                state_q     <= S_RO_READ;
                            end else begin
                                shreg_q  <= shreg_q >> 1;
                                ro_pos_q <= ro_pos_q + PW'(1);
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback: behavioural registered-read SRAM, trellis-path frame builder,
// and a queue of expected decoded bits consumed as the stream emerges.
module tb_viterbi_traceback;

    localparam int NS       = 16;
    localparam int MAX_LEN  = 2048;
    localparam int OUT_BASE = 2048;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        dec_valid, dec_first, dec_last;
    logic [15:0] dec;
    logic [3:0]  end_state;
    logic        in_ready, mem_wr_en, mem_rd_en;
    logic [11:0] mem_addr;
    logic [23:0] mem_wdata, mem_rdata;
    logic        bit_valid, bit_out, bit_last, bit_ready, busy, err_len;

    always #5 clk = ~clk;

    viterbi_traceback #(.NS(NS), .MAX_LEN(MAX_LEN), .OUT_BASE(OUT_BASE)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .dec_valid_i(dec_valid), .dec_i(dec), .dec_first_i(dec_first), .dec_last_i(dec_last),
        .end_state_i(end_state), .in_ready_o(in_ready),
        .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .bit_valid_o(bit_valid), .bit_o(bit_out), .bit_last_o(bit_last), .bit_ready_i(bit_ready),
        .busy_o(busy), .err_len_o(err_len)
    );

    logic [23:0] sram [4096];
    always @(posedge clk) begin
        if (mem_wr_en) sram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    typedef struct packed { logic [11:0] addr; logic [23:0] data; } wr_t;
    typedef struct packed { logic b; logic last; } exp_t;

    wr_t  tb_wr_q[$];
    exp_t exp_q[$];
    int   overlap_cnt = 0, high_wr_cnt = 0, err_cnt = 0;
    int   pass_cnt = 0, total_cnt = 0;

    bit          u_arr   [MAX_LEN];
    logic [15:0] dec_arr [MAX_LEN];

    always @(negedge clk) begin
        wr_t w;
        if (mem_wr_en && mem_rd_en) overlap_cnt++;
        if (mem_wr_en && busy && !in_ready) begin
            w.addr = mem_addr;
            w.data = mem_wdata;
            tb_wr_q.push_back(w);
        end
        if (mem_wr_en && in_ready && mem_addr >= 12'(MAX_LEN)) high_wr_cnt++;
        if (err_len) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds a frame on a real trellis path: the decision of the path state at each step is
    // the MSB shifted out of the previous state; all other decision bits are random.
    task automatic send_frame(input int len, input bit tail_zero);
        logic [3:0] prev, s, end_st;
        logic [15:0] d;
        exp_t e;
        prev = '0;
        s = '0;
        for (int k = 0; k < len; k++) begin
            u_arr[k] = (tail_zero && k >= len - 4) ? 1'b0 : 1'($urandom_range(0, 1));
            s = {prev[2:0], u_arr[k]};
            d = 16'($urandom);
            d[s] = prev[3];
            dec_arr[k] = d;
            prev = s;
            e.b = u_arr[k];
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
        end_st = s;
        for (int k = 0; k < len; k++) begin
            dec_valid = 1'b1;
            dec       = dec_arr[k];
            dec_first = (k == 0);
            dec_last  = (k == len - 1);
            end_state = (k == len - 1) ? end_st : 4'($urandom);
            tick();
        end
        dec_valid = 1'b0;
        dec_first = 1'b0;
        dec_last  = 1'b0;
    endtask

    task automatic drain(input int n, input bit stall);
        bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   got = 0, cyc = 0;
        logic prev_stall = 1'b0, prev_bit = 1'b0, prev_last = 1'b0;
        exp_t e;
        while (got < n && cyc < n * 8 + 200) begin
            bit_ready = stall ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (bit_valid) begin
                if (prev_stall) begin
                    total_cnt++;
                    if ({bit_out, bit_last} !== {prev_bit, prev_last})
                        $display("FAIL stall_hold: bit/last=%b%b held value %b%b", bit_out, bit_last, prev_bit, prev_last);
                    else pass_cnt++;
                end
                if (bit_ready) begin
                    e = exp_q.pop_front();
                    total_cnt++;
                    if ({bit_out, bit_last} !== {e.b, e.last})
                        $display("FAIL bit[%0d]: bit/last=%b%b expected %b%b", got, bit_out, bit_last, e.b, e.last);
                    else pass_cnt++;
                    got++;
                end
                prev_stall = !bit_ready;
                prev_bit   = bit_out;
                prev_last  = bit_last;
            end else begin
                if (prev_stall) begin
                    total_cnt++;
                    $display("FAIL stall_drop: bit_valid=0 while a stalled bit was pending, expected 1");
                end
                prev_stall = 1'b0;
            end
            tick();
            cyc++;
        end
        bit_ready = 1'b0;
        total_cnt++;
        if (got != n) $display("FAIL bit_count: got %0d bits, expected %0d", got, n);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, bit_valid} !== 2'b00)
            $display("FAIL idle_after_stream: busy/valid=%b%b expected 00", busy, bit_valid);
        else pass_cnt++;
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if ({in_ready, busy, mem_wr_en, mem_rd_en, bit_valid, bit_last, err_len} !== 7'b1000000)
            $display("FAIL reset_state: rdy/busy/wr/rd/vld/last/err=%b expected 1000000",
                     {in_ready, busy, mem_wr_en, mem_rd_en, bit_valid, bit_last, err_len});
        else pass_cnt++;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_during_tb();
        send_frame(30, 1'b0);
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL tb_entered: busy/rdy=%b expected 10", {busy, in_ready});
        else pass_cnt++;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({mem_wr_en, mem_rd_en, busy, in_ready, bit_valid} !== 5'b00010)
            $display("FAIL reset_mid_tb: wr/rd/busy/rdy/vld=%b expected 00010",
                     {mem_wr_en, mem_rd_en, busy, in_ready, bit_valid});
        else pass_cnt++;
        tick();
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        total_cnt++;
        if ({busy, in_ready} !== 2'b01) $display("FAIL after_reset_idle: busy/rdy=%b expected 01", {busy, in_ready});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_single_step();
        exp_t e;
        tb_wr_q.delete();
        dec_valid = 1'b1; dec = 16'h0001; dec_first = 1'b1; dec_last = 1'b1; end_state = 4'h3;
        tick();
        dec_valid = 1'b0; dec_first = 1'b0; dec_last = 1'b0;
        e.b = 1'b1;
        e.last = 1'b1;
        exp_q.push_back(e);
        drain(1, 1'b0);
        total_cnt++;
        if (tb_wr_q.size() != 1) $display("FAIL l1_wr_count: %0d tb writes, expected 1", tb_wr_q.size());
        else pass_cnt++;
        if (tb_wr_q.size() >= 1) begin
            total_cnt++;
            if ({tb_wr_q[0].addr, tb_wr_q[0].data} !== {12'd2048, 24'h000001})
                $display("FAIL l1_word: addr/data=%0d/%h expected 2048/000001", tb_wr_q[0].addr, tb_wr_q[0].data);
            else pass_cnt++;
        end
    endtask

    task automatic test_k5_48();
        logic [23:0] w0, w1;
        tb_wr_q.delete();
        send_frame(48, 1'b1);
        for (int i = 0; i < 24; i++) begin
            w0[i] = u_arr[i];
            w1[i] = u_arr[24 + i];
        end
        drain(48, 1'b0);
        total_cnt++;
        if (tb_wr_q.size() != 2) $display("FAIL l48_wr_count: %0d tb writes, expected 2", tb_wr_q.size());
        else pass_cnt++;
        if (tb_wr_q.size() >= 2) begin
            total_cnt++;
            if ({tb_wr_q[0].addr, tb_wr_q[0].data} !== {12'd2049, w1})
                $display("FAIL l48_word1: addr/data=%0d/%h expected 2049/%h", tb_wr_q[0].addr, tb_wr_q[0].data, w1);
            else pass_cnt++;
            total_cnt++;
            if ({tb_wr_q[1].addr, tb_wr_q[1].data} !== {12'd2048, w0})
                $display("FAIL l48_word0: addr/data=%0d/%h expected 2048/%h", tb_wr_q[1].addr, tb_wr_q[1].data, w0);
            else pass_cnt++;
        end
    endtask

    task automatic test_partial_word();
        tb_wr_q.delete();
        send_frame(25, 1'b0);
        drain(25, 1'b0);
        total_cnt++;
        if (tb_wr_q.size() < 1 || {tb_wr_q[0].addr, tb_wr_q[0].data} !== {12'd2049, 23'd0, u_arr[24]})
            $display("FAIL l25_top_word: first tb write addr/data=%0d/%h expected 2049/%h",
                     tb_wr_q.size() ? tb_wr_q[0].addr : 12'd0, tb_wr_q.size() ? tb_wr_q[0].data : 24'd0,
                     {23'd0, u_arr[24]});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        send_frame(30, 1'b0);
        drain(30, 1'b1);
    endtask

    task automatic test_restart();
        for (int k = 0; k < 10; k++) begin
            dec_valid = 1'b1; dec = 16'($urandom); dec_first = (k == 0); dec_last = 1'b0;
            tick();
        end
        send_frame(8, 1'b0);
        drain(8, 1'b0);
    endtask

    task automatic test_overflow();
        high_wr_cnt = 0;
        err_cnt = 0;
        for (int k = 0; k <= MAX_LEN; k++) begin
            dec_valid = 1'b1;
            dec       = 16'(k * 7 + 3);
            dec_first = (k == 0);
            dec_last  = 1'b0;
            tick();
        end
        dec_valid = 1'b0;
        dec_first = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if (high_wr_cnt != 0) $display("FAIL ovf_write: %0d writes at addr>=2048, expected 0", high_wr_cnt);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt != 1) $display("FAIL ovf_err_pulse: %0d err cycles, expected 1", err_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({busy, in_ready} !== 2'b01) $display("FAIL ovf_idle: busy/rdy=%b expected 01", {busy, in_ready});
        else pass_cnt++;
        total_cnt++;
        if (sram[2047] !== {8'd0, 16'(2047 * 7 + 3)})
            $display("FAIL ovf_last_step: sram[2047]=%h expected %h", sram[2047], {8'd0, 16'(2047 * 7 + 3)});
        else pass_cnt++;
        tick();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dec_valid = 1'b0; dec_first = 1'b0; dec_last = 1'b0;
        dec = '0; end_state = '0; bit_ready = 1'b0; rst_i = 1'b1;
        test_reset();
        test_reset_during_tb();
        test_single_step();
        test_k5_48();
        test_partial_word();
        test_backpressure();
        test_restart();
        test_overflow();
        total_cnt++;
        if (overlap_cnt != 0) $display("FAIL rd_wr_overlap: %0d cycles with both enables, expected 0", overlap_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
